// File: rtl/cave_mem_pkg.sv
// Shared definitions for the memory-side read path.
// Holds the default bus widths, the default line length, the responder
// state encoding and small helpers that split a byte address into
// tag / word index / byte offset fields.
package cave_mem_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned BURST_LEN  = 4;

  localparam int unsigned OFFS_BITS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_BITS  = $clog2(BURST_LEN);
  localparam int unsigned TAG_BITS  = ADDR_WIDTH - OFFS_BITS - IDX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    BURST_REQ,
    FILL
  } state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1 -: TAG_BITS];
  endfunction

  function automatic logic [IDX_BITS-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFS_BITS +: IDX_BITS];
  endfunction

  function automatic logic [OFFS_BITS-1:0] addr_offs(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFS_BITS-1:0];
  endfunction

endpackage

// File: rtl/read_line_responder_if.sv
// Bundle of the upstream read port (io_in_*), the memory burst port
// (io_mem_*) and the line-buffer flush strobe.
//   slave  : the responder's view (drives wait_n/valid/dout and mem rd/addr/len)
//   master : the environment's view (request FIFO + memory controller)
interface read_line_responder_if #(
  parameter int unsigned ADDR_WIDTH = cave_mem_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = cave_mem_pkg::DATA_WIDTH
);

  logic                  io_in_rd;
  logic [ADDR_WIDTH-1:0] io_in_addr;
  logic                  io_in_wait_n;
  logic                  io_in_valid;
  logic [DATA_WIDTH-1:0] io_in_dout;

  logic                  io_mem_rd;
  logic [ADDR_WIDTH-1:0] io_mem_addr;
  logic [7:0]            io_mem_burstLength;
  logic                  io_mem_waitReq;
  logic                  io_mem_valid;
  logic [DATA_WIDTH-1:0] io_mem_dout;

  logic                  io_flush;

  modport slave (
    input  io_in_rd, io_in_addr, io_mem_waitReq, io_mem_valid, io_mem_dout, io_flush,
    output io_in_wait_n, io_in_valid, io_in_dout, io_mem_rd, io_mem_addr, io_mem_burstLength
  );

  modport master (
    output io_in_rd, io_in_addr, io_mem_waitReq, io_mem_valid, io_mem_dout, io_flush,
    input  io_in_wait_n, io_in_valid, io_in_dout, io_mem_rd, io_mem_addr, io_mem_burstLength
  );

endinterface

// File: rtl/line_buffer.sv
// One-line register file: DEPTH words of WIDTH bits.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : combinational read word index
//   rdata : combinational read data
// Contents are not reset; the owner tracks validity separately.
module line_buffer
  import cave_mem_pkg::*;
#(
  parameter int unsigned DEPTH = BURST_LEN,
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/read_line_responder.sv
// Memory-side responder of the rd/addr -> dout/valid/wait_n read protocol.
// Keeps a single line of BURST_LEN words. Hits return the word one cycle
// after acceptance; misses fetch the whole aligned line with one burst and
// return the requested word as its beat arrives.
//   clock, reset : clock and asynchronous active-high reset
//   bus.io_in_*  : upstream request / response port
//   bus.io_mem_* : burst read port toward memory
//   bus.io_flush : invalidate the line buffer
module read_line_responder #(
  parameter int unsigned ADDR_WIDTH = cave_mem_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = cave_mem_pkg::DATA_WIDTH,
  parameter int unsigned BURST_LEN  = cave_mem_pkg::BURST_LEN
) (
  input  logic                 clock,
  input  logic                 reset,
  read_line_responder_if.slave bus
);

  import cave_mem_pkg::*;

  localparam int unsigned L_OFFS_BITS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned L_IDX_BITS  = $clog2(BURST_LEN);
  localparam int unsigned L_TAG_BITS  = ADDR_WIDTH - L_OFFS_BITS - L_IDX_BITS;

  localparam logic [L_IDX_BITS:0] BEAT_LAST   = (L_IDX_BITS + 1)'(BURST_LEN - 1);
  localparam logic [7:0]          BURST_LEN_B = 8'(BURST_LEN);

  state_e                  state_q, state_d;
  logic                    line_valid_q, line_valid_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [L_TAG_BITS-1:0]   line_tag_q, line_tag_d;
  logic [L_IDX_BITS-1:0]   req_idx_q, req_idx_d;
  logic [L_IDX_BITS:0]     beat_q, beat_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;

  logic [L_TAG_BITS-1:0]   in_tag;
  logic [L_IDX_BITS-1:0]   in_idx;
  logic                    hit;
  logic                    buf_we;
  logic [DATA_WIDTH-1:0]   buf_rdata;
  logic                    unused_offs;

  assign in_tag      = bus.io_in_addr[ADDR_WIDTH-1 -: L_TAG_BITS];
  assign in_idx      = bus.io_in_addr[L_OFFS_BITS +: L_IDX_BITS];
  assign unused_offs = ^bus.io_in_addr[L_OFFS_BITS-1:0];

  // A flush in the same cycle as the request forces the miss path.
  assign hit = line_valid_q && (in_tag == line_tag_q) && !bus.io_flush;

  line_buffer #(
    .DEPTH (BURST_LEN),
    .WIDTH (DATA_WIDTH)
  ) u_line_buffer (
    .clk   (clock),
    .we    (buf_we),
    .waddr (beat_q[L_IDX_BITS-1:0]),
    .wdata (bus.io_mem_dout),
    .raddr (in_idx),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      line_tag_q   <= '0;
      req_idx_q    <= '0;
      beat_q       <= '0;
      valid_q      <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      flush_pend_q <= flush_pend_d;
      line_tag_q   <= line_tag_d;
      req_idx_q    <= req_idx_d;
      beat_q       <= beat_d;
      valid_q      <= valid_d;
      dout_q       <= dout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    flush_pend_d = flush_pend_q;
    line_tag_d   = line_tag_q;
    req_idx_d    = req_idx_q;
    beat_d       = beat_q;
    valid_d      = 1'b0;
    dout_d       = dout_q;
    buf_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (bus.io_flush) begin
          line_valid_d = 1'b0;
        end
        if (bus.io_in_rd) begin
          if (hit) begin
            valid_d = 1'b1;
            dout_d  = buf_rdata;
          end else begin
            line_tag_d   = in_tag;
            req_idx_d    = in_idx;
            line_valid_d = 1'b0;
            state_d      = BURST_REQ;
          end
        end
      end

      BURST_REQ: begin
        if (bus.io_flush) begin
          flush_pend_d = 1'b1;
        end
        if (!bus.io_mem_waitReq) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end

      FILL: begin
        if (bus.io_flush) begin
          flush_pend_d = 1'b1;
        end
        if (bus.io_mem_valid) begin
          buf_we = 1'b1;
          beat_d = beat_q + 1'b1;
          // Requested word is forwarded straight from the beat, not re-read.
          if (beat_q[L_IDX_BITS-1:0] == req_idx_q) begin
            valid_d = 1'b1;
            dout_d  = bus.io_mem_dout;
          end
          if (beat_q == BEAT_LAST) begin
            // A flush landing on the final beat also leaves the line invalid.
            line_valid_d = !(flush_pend_q || bus.io_flush);
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.io_in_wait_n       = (state_q == IDLE);
    bus.io_in_valid        = valid_q;
    bus.io_in_dout         = dout_q;
    bus.io_mem_rd          = (state_q == BURST_REQ);
    bus.io_mem_addr        = {line_tag_q, {(L_IDX_BITS + L_OFFS_BITS){1'b0}}};
    bus.io_mem_burstLength = BURST_LEN_B;
  end

endmodule

// File: tb/tb_read_line_responder.sv
module tb_read_line_responder;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned BL = 4;

  logic clk;
  logic rst;
  int   cyc;

  int n_checks;
  int n_errors;

  // reference model state: which line (if any) the responder should be holding
  bit          m_valid;
  logic [26:0] m_tag;

  // memory-side configuration (written by main) and observations (written by memory process)
  int cfg_wait;
  int cfg_gap;
  int cfg_abort;
  bit stray_go;
  int beat_cyc [BL];
  bit abort_done;
  bit stray_done;
  int hold_err;
  int drop_err;

  logic [31:0] hs_addr [8];

  read_line_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  read_line_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents are a fixed function of the word address.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    return {a ^ 32'hC0DE_0000, h};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory controller: answers each burst request with optional waitReq
  // stalls, gapped beats, an optional abort, and one-shot stray beats.
  initial begin : mem_proc
    logic [31:0] base;
    int w;
    int g;
    bus.io_mem_waitReq = 1'b0;
    bus.io_mem_valid   = 1'b0;
    bus.io_mem_dout    = '0;
    abort_done = 1'b0;
    stray_done = 1'b0;
    hold_err   = 0;
    drop_err   = 0;
    for (int i = 0; i < int'(BL); i++) beat_cyc[i] = 0;
    forever begin
      @(negedge clk);
      bus.io_mem_valid = 1'b0;
      bus.io_mem_dout  = {$urandom, $urandom};
      if (stray_go && !stray_done) begin
        bus.io_mem_valid = 1'b1;
        @(negedge clk);
        bus.io_mem_dout  = {$urandom, $urandom};
        @(negedge clk);
        bus.io_mem_valid = 1'b0;
        stray_done = 1'b1;
      end else if (!rst && bus.io_mem_rd) begin
        base = bus.io_mem_addr;
        w = (cfg_wait >= 0) ? cfg_wait : int'($urandom_range(0, 3));
        for (int k = 0; k < w; k++) begin
          bus.io_mem_waitReq = 1'b1;
          @(negedge clk);
          if (bus.io_mem_rd !== 1'b1 || bus.io_mem_addr !== base || bus.io_mem_burstLength !== 8'(BL))
            hold_err++;
        end
        bus.io_mem_waitReq = 1'b0;
        for (int i = 0; i < int'(BL); i++) begin
          g = (cfg_gap >= 0) ? cfg_gap : int'($urandom_range(0, 2));
          repeat (g) begin
            @(negedge clk);
            bus.io_mem_valid = 1'b0;
            bus.io_mem_dout  = {$urandom, $urandom};
          end
          @(negedge clk);
          if (i == 0 && bus.io_mem_rd !== 1'b0) drop_err++;
          bus.io_mem_valid = 1'b1;
          bus.io_mem_dout  = mem_word(base + 32'(8 * i));
          beat_cyc[i] = cyc;
          if (cfg_abort != 0 && i + 1 == cfg_abort) begin
            abort_done = 1'b1;
            break;
          end
        end
      end
    end
  end

  // One request; hit/miss is predicted from the model and every response
  // property (count, data, timing, memory request) is checked.
  task automatic do_read(input logic [31:0] a, input bit fl, input bit fl_in_fill);
    logic [31:0] base;
    int          idx;
    bit          hit;
    int          nresp;
    int          resp_cyc;
    logic [63:0] resp_dout;
    int          n;
    bit          done;
    bit          flushed;
    base = {a[31:5], 5'b0};
    idx  = int'(a[4:3]);
    @(negedge clk);
    check("accept_wait_n", 64'(bus.io_in_wait_n), 64'd1);
    bus.io_in_rd   = 1'b1;
    bus.io_in_addr = a;
    bus.io_flush   = fl;
    hit = m_valid && (a[31:5] == m_tag) && !fl;
    @(negedge clk);
    bus.io_in_rd   = 1'b0;
    bus.io_flush   = 1'b0;
    bus.io_in_addr = $urandom;
    if (hit) begin
      check("hit_valid", 64'(bus.io_in_valid), 64'd1);
      check("hit_dout", bus.io_in_dout, mem_word({a[31:3], 3'b0}));
      check("hit_no_mem_rd", 64'(bus.io_mem_rd), 64'd0);
    end else begin
      check("miss_no_early_resp", 64'(bus.io_in_valid), 64'd0);
      check("miss_mem_rd", 64'(bus.io_mem_rd), 64'd1);
      check("miss_mem_addr", 64'(bus.io_mem_addr), 64'(base));
      check("miss_burst_len", 64'(bus.io_mem_burstLength), 64'(BL));
      nresp = 0; resp_cyc = -1; resp_dout = '0;
      n = 0; done = 1'b0; flushed = 1'b0;
      while (!done && n < 200) begin
        @(negedge clk);
        n++;
        if (fl_in_fill && n == 1) begin
          bus.io_flush = 1'b1;
          flushed = 1'b1;
        end else begin
          bus.io_flush = 1'b0;
        end
        if (bus.io_in_valid === 1'b1) begin
          nresp++;
          resp_cyc  = cyc;
          resp_dout = bus.io_in_dout;
        end
        if (bus.io_in_wait_n === 1'b1) done = 1'b1;
      end
      bus.io_flush = 1'b0;
      check("miss_completes", 64'(bus.io_in_wait_n), 64'd1);
      check("miss_resp_count", 64'(nresp), 64'd1);
      check("miss_resp_dout", resp_dout, mem_word(base + 32'(8 * idx)));
      check("miss_resp_time", 64'(resp_cyc), 64'(beat_cyc[idx] + 1));
      check("miss_wait_n_time", 64'(cyc), 64'(beat_cyc[BL-1] + 1));
      check("mem_req_held", 64'(hold_err), 64'd0);
      check("mem_rd_dropped", 64'(drop_err), 64'd0);
      m_valid = !flushed;
      m_tag   = a[31:5];
    end
  endtask

  // Back-to-back hits to the current line from hs_addr[0..n-1].
  task automatic hit_stream(input int n);
    logic [31:0] prev;
    prev = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_valid", 64'(bus.io_in_valid), 64'd1);
        check("b2b_dout", bus.io_in_dout, mem_word({prev[31:3], 3'b0}));
      end
      check("b2b_wait_n", 64'(bus.io_in_wait_n), 64'd1);
      check("b2b_no_mem_rd", 64'(bus.io_mem_rd), 64'd0);
      bus.io_in_rd   = 1'b1;
      bus.io_in_addr = hs_addr[i];
      prev = hs_addr[i];
    end
    @(negedge clk);
    bus.io_in_rd = 1'b0;
    check("b2b_valid", 64'(bus.io_in_valid), 64'd1);
    check("b2b_dout", bus.io_in_dout, mem_word({prev[31:3], 3'b0}));
    check("b2b_no_mem_rd", 64'(bus.io_mem_rd), 64'd0);
    @(negedge clk);
    check("b2b_single_pulse", 64'(bus.io_in_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wait_n"}, 64'(bus.io_in_wait_n), 64'd1);
    check({tag, "_valid"}, 64'(bus.io_in_valid), 64'd0);
    check({tag, "_dout"}, bus.io_in_dout, 64'd0);
    check({tag, "_mem_rd"}, 64'(bus.io_mem_rd), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.io_mem_addr), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    logic [31:0] a;
    n_checks = 0;
    n_errors = 0;
    m_valid  = 1'b0;
    m_tag    = '0;
    cfg_wait = -1;
    cfg_gap  = -1;
    cfg_abort = 0;
    stray_go = 1'b0;
    rst = 1'b1;
    bus.io_in_rd   = 1'b0;
    bus.io_in_addr = '0;
    bus.io_flush   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // cold miss with three stall cycles, consecutive beats
    cfg_wait = 3; cfg_gap = 0;
    do_read(32'h100, 1'b0, 1'b0);

    // back-to-back hits, low address bits ignored
    hs_addr[0] = 32'h118;
    hs_addr[1] = 32'h10C;
    hit_stream(2);

    // miss on last word with gaps between beats
    cfg_wait = -1; cfg_gap = 2;
    do_read(32'h218, 1'b0, 1'b0);

    // flush during fill leaves the line invalid
    cfg_wait = 0; cfg_gap = 0;
    do_read(32'h300, 1'b0, 1'b1);
    cfg_wait = -1; cfg_gap = -1;
    do_read(32'h300, 1'b0, 1'b0);

    // flush together with a would-be hit forces a miss
    do_read(32'h100, 1'b0, 1'b0);
    do_read(32'h108, 1'b1, 1'b0);

    // reset in the middle of a fill, stray beats afterwards
    cfg_abort = 2;
    @(negedge clk);
    bus.io_in_rd = 1'b1;
    bus.io_in_addr = 32'h200;
    @(negedge clk);
    bus.io_in_rd = 1'b0;
    k = 0;
    while (!abort_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached", 64'(abort_done), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    cfg_abort = 0;
    @(negedge clk);
    check_reset_outputs("mid_fill_reset");
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    stray_go = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stray_no_valid", 64'(bus.io_in_valid), 64'd0);
      check("stray_no_mem_rd", 64'(bus.io_mem_rd), 64'd0);
      check("stray_wait_n", 64'(bus.io_in_wait_n), 64'd1);
    end
    do_read(32'h100, 1'b0, 1'b0);

    // randomized traffic over a handful of lines
    for (int it = 0; it < 60; it++) begin
      if (m_valid && $urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(1, 6));
        for (int j = 0; j < k; j++)
          hs_addr[j] = {m_tag, 5'b0} | 32'($urandom_range(0, 31));
        hit_stream(k);
      end else begin
        a = 32'h100 * 32'($urandom_range(1, 4)) + 32'($urandom_range(0, 31));
        do_read(a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/read_line_responder.md
Name: read_line_responder

Overview:
- Responder end of the single-clock rd/addr → dout/valid/wait_n read protocol.
- Sits on the fast-clock side, on the memory side of the clock-domain crossing. It serves 64-bit word reads from the crossing's request FIFO.
- Keeps one line buffer of BURST_LEN words. Hits are answered from the buffer in one cycle.
- Misses issue one line-aligned burst to the memory port, fill the buffer, and return the requested word when its beat arrives.

Parameters:
- ADDR_WIDTH, 32, byte address width on both ports.
- DATA_WIDTH, 64, word width. Must be a power of two and at least 8.
- BURST_LEN, 4, words per line and per burst. Power of two, 2..64.
- OFFS_BITS = log2(DATA_WIDTH/8) = 3, derived.
- IDX_BITS = log2(BURST_LEN) = 2, derived.
- TAG_BITS = ADDR_WIDTH - OFFS_BITS - IDX_BITS, derived.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- io_in_rd  in  1  read request.
- io_in_addr  in  ADDR_WIDTH  byte address; low OFFS_BITS are ignored.
- io_in_wait_n  out  1  request accepted this cycle when io_in_rd & io_in_wait_n.
- io_in_valid  out  1  one-cycle pulse, response data valid.
- io_in_dout  out  DATA_WIDTH  response word.
- io_mem_rd  out  1  burst read request.
- io_mem_addr  out  ADDR_WIDTH  line-aligned burst address.
- io_mem_burstLength  out  8  always BURST_LEN.
- io_mem_waitReq  in  1  memory stall; the request is held while high.
- io_mem_valid  in  1  read beat valid.
- io_mem_dout  in  DATA_WIDTH  read beat data.
- io_flush  in  1  invalidate line buffer.

Behaviour:
- Decided: one clock `clock`; reset `reset` is asynchronous, active-high.
- Address split:
  - tag = addr[ADDR_WIDTH-1 : OFFS_BITS+IDX_BITS]
  - idx = addr[OFFS_BITS+IDX_BITS-1 : OFFS_BITS]
- Reset values:
  - state IDLE, lineValid 0, beat counter 0.
  - io_in_valid 0, io_in_dout 0.
  - io_mem_rd 0, io_mem_addr 0.
  - io_in_wait_n is 1, since it is combinational from IDLE.
- io_in_wait_n = (state == IDLE). io_in_valid and io_in_dout are registered outputs.
- IDLE:
  - Accept when io_in_rd.
  - Hit (lineValid & tag == lineTag & !io_flush): next cycle io_in_valid=1 and io_in_dout=buffer[idx]. Latency 1, and a new request can be accepted every cycle.
  - Miss: latch reqIdx and lineTag := tag, clear lineValid, go to BURST_REQ. No response is produced this cycle.
- BURST_REQ:
  - io_mem_rd=1, io_mem_addr = {lineTag, IDX_BITS'0, OFFS_BITS'0}, io_mem_burstLength=BURST_LEN.
  - Hold all three while io_mem_waitReq=1.
  - On the first cycle with !io_mem_waitReq, go to FILL with beat=0.
  - io_mem_rd=0 in every other state.
- FILL:
  - Each io_mem_valid writes buffer[beat] := io_mem_dout and increments beat.
  - If beat == reqIdx on that cycle, next cycle io_in_valid=1 with io_in_dout = that io_mem_dout (bypass, not a buffer read).
  - On the beat == BURST_LEN-1 valid: lineValid := !flushPending, clear flushPending, go to IDLE. A request can be accepted on the following cycle.
- Only one response is issued per accepted request. io_in_valid is never asserted in consecutive cycles for the same request.
- io_flush:
  - In IDLE it clears lineValid immediately, and a same-cycle request is treated as a miss.
  - In BURST_REQ/FILL it sets flushPending, so the in-flight line completes but is left invalid.
- Ignored inputs:
  - io_mem_valid outside FILL is ignored; stale beats after reset are dropped.
  - io_in_rd while wait_n=0 is ignored; the upstream FIFO holds it.
- Async reset mid-burst abandons the burst. The memory side is expected to be reset together with this block.
- The beat counter is IDX_BITS+1 wide and cannot wrap within a burst.

Decomposition:
- Shared package (cave_mem_pkg) holds:
  - state enum {IDLE, BURST_REQ, FILL}.
  - Address-split helper functions for tag/idx/offset.
  - Width constants ADDR_WIDTH and DATA_WIDTH.
- One sub-module, line_buffer: BURST_LEN x DATA_WIDTH register file with one write port and one combinational read port.

Test Plan:
- Cold read 0x100: io_mem_addr=0x100, burstLength=4; beats D0..D3 with waitReq=1 for 3 cycles → io_in_valid one cycle after D0 beat, dout=D0; wait_n low until the cycle after the D3 beat.
- After the line is filled, back-to-back reads 0x118, 0x10C (low bits ignored) → dout D3 then D1 on consecutive cycles, io_mem_rd stays 0.
- Miss at 0x218 (idx 3) with gaps between beats → single io_in_valid cycle after the 4th beat, dout=that beat; no earlier response.
- io_flush pulsed during FILL of 0x300, then read 0x300 → new burst issued to 0x300.
- io_flush together with rd 0x100 in IDLE with a valid line → treated as a miss, burst to 0x100.
- Reset asserted mid-FILL after 2 beats, 2 more beats arrive → outputs at reset values, stray beats ignored, next read 0x100 issues a fresh burst.
